// File: rtl/load_hazard_stall_unit_if.sv
// load_hazard_stall_unit_if: hazard inputs from ID/EX/MEM and stall controls back to the pipeline.
interface load_hazard_stall_unit_if #(
    parameter int REG_W  = 5,
    parameter int CW     = 2,
    parameter int PERF_W = 16
);
    logic [REG_W-1:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic              id_uses_rs, id_uses_rt, id_is_branch;
    logic              ex_regwrite, ex_memread, mem_regwrite, mem_memread, ext_hold;
    logic              pcwrite, if_id_write, id_flush, stall_active;
    logic [CW-1:0]     stall_cnt;
    logic [PERF_W-1:0] stall_cycles;
    modport master (
        output id_rs, id_rt, ex_rd, mem_rd, id_uses_rs, id_uses_rt, id_is_branch,
               ex_regwrite, ex_memread, mem_regwrite, mem_memread, ext_hold,
        input  pcwrite, if_id_write, id_flush, stall_active, stall_cnt, stall_cycles
    );
    modport slave (
        input  id_rs, id_rt, ex_rd, mem_rd, id_uses_rs, id_uses_rt, id_is_branch,
               ex_regwrite, ex_memread, mem_regwrite, mem_memread, ext_hold,
        output pcwrite, if_id_write, id_flush, stall_active, stall_cnt, stall_cycles
    );
endinterface

// File: rtl/load_hazard_stall_unit.sv
// load_hazard_stall_unit: counter-based load-use / branch-operand stall sequencer beside ID.
module load_hazard_stall_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 0,
    parameter int PERF_W       = 16,
    parameter int CW           = $clog2(LOAD_LAT + 2)
) (
    input logic clk,
    input logic reset_n,
    load_hazard_stall_unit_if.slave bus
);
    typedef enum logic {IDLE, STALL} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [PERF_W-1:0] perf;
    logic              ex_hit, mem_hit, br, stall;
    logic [CW-1:0]     need;
    assign ex_hit  = bus.ex_rd != '0 && ((bus.id_uses_rs && bus.ex_rd == bus.id_rs) ||
                                         (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
    assign mem_hit = bus.mem_rd != '0 && ((bus.id_uses_rs && bus.mem_rd == bus.id_rs) ||
                                          (bus.id_uses_rt && bus.mem_rd == bus.id_rt));
    assign br      = BRANCH_IN_ID != 0 && bus.id_is_branch;
    // a load hazard always needs >=1 bubble, so it dominates the single-bubble branch cases
    assign need = (bus.ex_memread && ex_hit) ? CW'(LOAD_LAT) + CW'(br) :
                  (br && ((bus.ex_regwrite && ex_hit) || (bus.mem_memread && mem_hit))) ? CW'(1) : '0;
    assign stall = reset_n && !bus.ext_hold && (state == STALL || need != '0);
    assign bus.id_flush     = stall;
    assign bus.pcwrite      = !stall && !(reset_n && bus.ext_hold);
    assign bus.if_id_write  = !stall && !(reset_n && bus.ext_hold);
    assign bus.stall_active = reset_n && state == STALL;
    assign bus.stall_cnt    = cnt;
    assign bus.stall_cycles = perf;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            perf  <= '0;
        end else begin
            if (stall && perf != '1) perf <= perf + 1'b1;
            if (!bus.ext_hold) begin
                if (state == STALL) begin
                    state <= (cnt == CW'(1)) ? IDLE : STALL;
                    cnt   <= cnt - 1'b1;
                end else if (need > CW'(1)) begin
                    state <= STALL;
                    cnt   <= need - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_hazard_stall_unit.sv
// tb_load_hazard_stall_unit: two parameterisations driven in lockstep against a remaining-bubbles model.
module tb_load_hazard_stall_unit;
    typedef struct packed {
        logic rn, hold, br, urs, urt, exw, exm, mw, mm;
        logic [4:0] rs, rt, exd, md;
    } stim_t;
    typedef struct {
        logic pc, ifid, fl, act;
        int   cnt, cyc;
    } exp_t;

    logic  clk = 0;
    logic  reset_n;
    stim_t s;
    exp_t  q[$];
    int    nvec = 0, nerr = 0;
    int    rem[2], perf[2];
    int    ll[2]   = '{1, 3};
    int    brm[2]  = '{0, 1};
    int    pmax[2] = '{65535, 3};

    always #5 clk = ~clk;

    load_hazard_stall_unit_if #(.REG_W(5), .CW(2), .PERF_W(16)) ia ();
    load_hazard_stall_unit_if #(.REG_W(5), .CW(3), .PERF_W(2))  ib ();

    load_hazard_stall_unit ua (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
    load_hazard_stall_unit #(.LOAD_LAT(3), .BRANCH_IN_ID(1), .PERF_W(2)) ub (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        reset_n = s.rn;
        ia.id_rs = s.rs; ia.id_rt = s.rt; ia.ex_rd = s.exd; ia.mem_rd = s.md;
        ia.id_uses_rs = s.urs; ia.id_uses_rt = s.urt; ia.id_is_branch = s.br;
        ia.ex_regwrite = s.exw; ia.ex_memread = s.exm; ia.mem_regwrite = s.mw;
        ia.mem_memread = s.mm; ia.ext_hold = s.hold;
        ib.id_rs = s.rs; ib.id_rt = s.rt; ib.ex_rd = s.exd; ib.mem_rd = s.md;
        ib.id_uses_rs = s.urs; ib.id_uses_rt = s.urt; ib.id_is_branch = s.br;
        ib.ex_regwrite = s.exw; ib.ex_memread = s.exm; ib.mem_regwrite = s.mw;
        ib.mem_memread = s.mm; ib.ext_hold = s.hold;
    endtask

    function automatic bit hit(logic [4:0] rd);
        return rd != 0 && ((s.urs && rd == s.rs) || (s.urt && rd == s.rt));
    endfunction

    function automatic int need(int k);
        int n = 0;
        bool_br: begin end
        if (s.exm && hit(s.exd)) n = ll[k] + ((brm[k] != 0 && s.br) ? 1 : 0);
        if (brm[k] != 0 && s.br && s.exw && !s.exm && hit(s.exd) && n < 1) n = 1;
        if (brm[k] != 0 && s.br && s.mm && hit(s.md) && n < 1) n = 1;
        return n;
    endfunction

    task automatic apply();
        exp_t e;
        int   nr[2], np[2], n;
        drive();
        for (int k = 0; k < 2; k++) begin
            n = need(k);
            nr[k] = rem[k];
            np[k] = perf[k];
            e.cnt = rem[k];
            e.cyc = perf[k];
            if (!s.rn) begin
                e.pc = 1; e.ifid = 1; e.fl = 0; e.act = 0;
                nr[k] = 0; np[k] = 0;
            end else if (s.hold) begin
                e.pc = 0; e.ifid = 0; e.fl = 0; e.act = rem[k] > 0;
            end else if (rem[k] > 0 || n > 0) begin
                e.pc = 0; e.ifid = 0; e.fl = 1; e.act = rem[k] > 0;
                nr[k] = rem[k] > 0 ? rem[k] - 1 : n - 1;
                np[k] = perf[k] < pmax[k] ? perf[k] + 1 : perf[k];
            end else begin
                e.pc = 1; e.ifid = 1; e.fl = 0; e.act = 0;
            end
            q.push_back(e);
        end
        @(negedge clk);
        e = q.pop_front();
        check("a.pcwrite", 32'(ia.pcwrite), 32'(e.pc));
        check("a.if_id_write", 32'(ia.if_id_write), 32'(e.ifid));
        check("a.id_flush", 32'(ia.id_flush), 32'(e.fl));
        check("a.stall_active", 32'(ia.stall_active), 32'(e.act));
        check("a.stall_cnt", 32'(ia.stall_cnt), e.cnt);
        check("a.stall_cycles", 32'(ia.stall_cycles), e.cyc);
        e = q.pop_front();
        check("b.pcwrite", 32'(ib.pcwrite), 32'(e.pc));
        check("b.if_id_write", 32'(ib.if_id_write), 32'(e.ifid));
        check("b.id_flush", 32'(ib.id_flush), 32'(e.fl));
        check("b.stall_active", 32'(ib.stall_active), 32'(e.act));
        check("b.stall_cnt", 32'(ib.stall_cnt), e.cnt);
        check("b.stall_cycles", 32'(ib.stall_cycles), e.cyc);
        rem = nr;
        perf = np;
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        s = '0;
        s.rn = 1;
    endtask

    task automatic idle(input int n);
        clear();
        for (int i = 0; i < n; i++) apply();
    endtask

    task automatic load(input logic [4:0] rd, input logic branch);
        clear();
        s.exm = 1; s.exw = 1; s.exd = rd; s.br = branch;
        s.rs = rd; s.urs = 1;
    endtask

    initial begin
        rem = '{0, 0};
        perf = '{0, 0};
        clear();
        s.rn = 0;
        drive();
        @(posedge clk);
        #1;
        apply();
        apply();
        idle(2);
        // classic load-use, then the bubble
        load(5'd3, 0);
        apply();
        idle(4);
        // r0 and unused-source filtering
        load(5'd0, 0);
        apply();
        load(5'd3, 0);
        s.urs = 0;
        apply();
        idle(1);
        // load feeding a branch through rt
        clear();
        s.br = 1; s.exm = 1; s.exw = 1; s.exd = 5; s.rt = 5; s.urt = 1;
        apply();
        idle(5);
        // ALU result feeding a branch
        clear();
        s.br = 1; s.exw = 1; s.exd = 7; s.rs = 7; s.urs = 1;
        apply();
        idle(1);
        // load in MEM feeding a branch
        clear();
        s.br = 1; s.mm = 1; s.mw = 1; s.md = 9; s.rt = 9; s.urt = 1;
        apply();
        idle(1);
        // freeze mid-stall
        load(5'd4, 0);
        apply();
        idle(1);
        clear();
        s.hold = 1;
        apply();
        apply();
        idle(4);
        // freeze over a detected hazard, then re-evaluate on release
        load(5'd6, 0);
        s.hold = 1;
        apply();
        s.hold = 0;
        apply();
        idle(4);
        // reset in the middle of a branch-load stall
        clear();
        s.br = 1; s.exm = 1; s.exw = 1; s.exd = 2; s.rs = 2; s.urs = 1;
        apply();
        idle(1);
        clear();
        s.rn = 0;
        apply();
        idle(2);
        for (int i = 0; i < 300; i++) begin
            s.rn   = $urandom_range(0, 29) != 0;
            s.hold = $urandom_range(0, 7) == 0;
            s.br   = 1'($urandom);
            s.urs  = 1'($urandom);
            s.urt  = 1'($urandom);
            s.exw  = 1'($urandom);
            s.exm  = $urandom_range(0, 2) == 0;
            s.mw   = 1'($urandom);
            s.mm   = $urandom_range(0, 2) == 0;
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.exd  = 5'($urandom_range(0, 3));
            s.md   = 5'($urandom_range(0, 3));
            apply();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
